// File: rtl/addsub_pkg.sv
// Shared types and op decode helpers for the digit-serial add/subtract unit.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_ADC = 2'b01,
    OP_SUB = 2'b10,
    OP_SBC = 2'b11
  } addsub_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  function automatic logic op_inverts_b(addsub_op_t op);
    return (op == OP_SUB) || (op == OP_SBC);
  endfunction

  // ARM carry convention: subtraction is a + ~b + 1, so C=1 means no borrow.
  function automatic logic op_carry_in(addsub_op_t op, logic cin);
    logic c;
    case (op)
      OP_ADD:  c = 1'b0;
      OP_SUB:  c = 1'b1;
      default: c = cin;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/digit_add.sv
// Combinational D-bit ripple adder; also exposes the carry into its MSB so the
// caller can derive signed overflow on the final digit.
module digit_add #(
  parameter int D = 8
) (
  input  logic [D-1:0] a,
  input  logic [D-1:0] b,
  input  logic         cin,
  output logic [D-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  always_comb begin
    logic [D:0] c;
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < D; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout  = c[D];
    c_msb = c[D-1];
  end

endmodule

// File: rtl/digit_serial_addsub.sv
// N-bit ADD/ADC/SUB/SBC computed D bits per clock through one digit_add,
// with NZCV flags and valid/ready handshakes on both sides.
//
//   state  | meaning
//   S_IDLE | waiting for an operation, in_ready=1
//   S_RUN  | one digit per edge, LSB digit first
//   S_DONE | result and flags valid, held until out_ready
module digit_serial_addsub
  import addsub_pkg::*;
#(
  parameter int N = 32,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  addsub_op_t   op,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         flag_n,
  output logic         flag_z,
  output logic         flag_c,
  output logic         flag_v
);

  localparam int NDIG = N / D;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if (N < 2 || D < 1 || D > N || (N % D) != 0) begin : g_bad_params
      $fatal(1, "digit_serial_addsub: need N >= 2, 1 <= D <= N and N %% D == 0");
    end
  endgenerate

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  a_q, b_q, work;
  logic          carry;

  logic [D-1:0]   d_sum;
  logic           d_cout, d_cmsb;
  logic [N+D-1:0] work_cat;
  logic [N-1:0]   work_nxt;
  logic           last;

  // Operands shift right each digit; the partial sum shifts in from the top,
  // so after N/D digits the first digit has landed at bits [D-1:0].
  digit_add #(.D(D)) u_digit_add (
    .a     (a_q[D-1:0]),
    .b     (b_q[D-1:0]),
    .cin   (carry),
    .sum   (d_sum),
    .cout  (d_cout),
    .c_msb (d_cmsb)
  );

  assign work_cat = {d_sum, work};
  assign work_nxt = work_cat[N+D-1:D];
  assign last     = (cnt == CW'(NDIG - 1));
  assign in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      work      <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          a_q   <= a_q >> D;
          b_q   <= b_q >> D;
          work  <= work_nxt;
          carry <= d_cout;
          if (last) begin
            sum       <= work_nxt;
            flag_n    <= work_nxt[N-1];
            flag_z    <= ~|work_nxt;
            flag_c    <= d_cout;
            flag_v    <= d_cmsb ^ d_cout;
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Acceptance overrides the DONE->IDLE move so a consume and a new
      // operation can share one edge.
      if (in_valid && in_ready) begin
        a_q   <= a;
        b_q   <= op_inverts_b(op) ? ~b : b;
        carry <= op_carry_in(op, cin);
        cnt   <= '0;
        state <= S_RUN;
      end
    end
  end

endmodule
